// File: rtl/boot_pkg.sv
// Shared definitions for the UART bootloader.
//   state_t   : main FSM state encoding (also exported on dbg_state)
//   CMD_WRITE : frame command that opens a memory-write transfer
//   CMD_RUN   : command that releases the CPU from reset after the ACK
//   RSP_ACK / RSP_NAK : single-byte responses sent back over the UART
package boot_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RESP_SEND,
    S_RESP_WAIT,
    S_RUN
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_RUN   = 8'h5A;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

endpackage

// File: rtl/boot_resp_tx.sv
// Response transmitter: issues the one-cycle trmt pulse, holds tx_data
// stable until the response completes, and waits for tx_done.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_start      : high for the single RESP_SEND cycle of the main FSM
//   i_byte       : response byte to transmit (valid while i_start)
//   i_tx_done    : UART transmit-complete flag
//   o_trmt       : transmit start pulse to the UART
//   o_tx_data    : byte presented to the UART
//   o_done       : response finished; main FSM may leave RESP_WAIT
module boot_resp_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_tx_done,
  output logic       o_trmt,
  output logic [7:0] o_tx_data,
  output logic       o_done
);

  logic [7:0] r_tx_data;
  logic       r_active;
  logic       r_first;   // first wait cycle: tx_done may still be stale

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data <= 8'h00;
      r_active  <= 1'b0;
      r_first   <= 1'b0;
    end else if (i_start) begin
      r_tx_data <= i_byte;
      r_active  <= 1'b1;
      r_first   <= 1'b1;
    end else if (r_active) begin
      r_first <= 1'b0;
      if (!r_first && i_tx_done) r_active <= 1'b0;
    end
  end

  assign o_trmt    = i_start;
  // The byte must already be on the bus in the trmt cycle itself.
  assign o_tx_data = i_start ? i_byte : r_tx_data;
  assign o_done    = r_active && !r_first && i_tx_done;

endmodule

// File: rtl/uart_bootloader.sv
// UART bootloader: parses write/run frames from a byte stream, writes
// 32-bit words into instruction memory, answers with ACK/NAK and finally
// releases the CPU from reset.
// Frame: A5 addr_hi addr_lo len_hi len_lo {4 bytes LE per word} csum
//        5A -> ACK, then CPU runs
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   rx_data, rx_rdy      : received byte and its pending flag
//   clr_rx_rdy           : combinational acknowledge of rx_data
//   tx_data, trmt        : response byte and transmit start pulse
//   tx_done              : UART transmit complete
//   mem_we/addr/wdata    : instruction memory write port
//   cpu_rst_n            : 1 releases the CPU (RUN state only)
//   busy                 : high outside IDLE and RUN
//   dbg_state            : current FSM state for observation
// Optional feature: define BOOT_TIMEOUT_EN to abort a stalled frame with
// NAK after TIMEOUT_CYC cycles without a byte.
// ADDR_W is at most 16 (the frame carries a 16-bit address).
module uart_bootloader
  import boot_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 20000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              clr_rx_rdy,
  output logic [7:0]        tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output state_t            dbg_state
);

  state_t            r_state, w_next;
  logic [7:0]        r_addr_hi, r_len_hi, r_csum, r_resp;
  logic [ADDR_W-1:0] r_base;
  logic [15:0]       r_len, r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word;     // first three bytes of the current word
  logic              r_run_ack;  // response in flight is the CMD_RUN ACK
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              w_accept, w_timeout, w_resp_done, w_in_frame, w_resp_start;

  // A byte is taken in every state except while a response is in flight;
  // gating with rst_n keeps the acknowledge low during reset.
  assign w_accept     = rst_n && rx_rdy &&
                        (r_state != S_RESP_SEND) && (r_state != S_RESP_WAIT);
  assign w_in_frame   = (r_state >= S_ADDR_HI) && (r_state <= S_CSUM);
  assign w_resp_start = (r_state == S_RESP_SEND);

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_to_cnt <= '0;
    else if (!w_in_frame || w_accept) r_to_cnt <= '0;
    else                             r_to_cnt <= r_to_cnt + 32'd1;
  end
  assign w_timeout = w_in_frame && !w_accept && (r_to_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC == 0) | w_in_frame;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (rx_data == CMD_WRITE)    w_next = S_ADDR_HI;
        else if (rx_data == CMD_RUN) w_next = S_RESP_SEND;
      end
      S_ADDR_HI: if (w_accept) w_next = S_ADDR_LO;
      S_ADDR_LO: if (w_accept) w_next = S_LEN_HI;
      S_LEN_HI:  if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO:  if (w_accept) w_next = ({r_len_hi, rx_data} == 16'd0) ? S_CSUM : S_DATA;
      S_DATA:    if (w_accept && (r_byte_idx == 2'd3) && ((r_word_idx + 16'd1) == r_len))
                   w_next = S_CSUM;
      S_CSUM:    if (w_accept) w_next = S_RESP_SEND;
      S_RESP_SEND: w_next = S_RESP_WAIT;
      S_RESP_WAIT: if (w_resp_done) w_next = r_run_ack ? S_RUN : S_IDLE;
      S_RUN:     w_next = S_RUN;
      default:   w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_RESP_SEND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_hi   <= '0;
      r_len_hi    <= '0;
      r_csum      <= '0;
      r_resp      <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_run_ack   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (rx_data == CMD_WRITE) begin
              r_csum     <= '0;
              r_run_ack  <= 1'b0;
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_word     <= '0;
            end else if (rx_data == CMD_RUN) begin
              r_resp    <= RSP_ACK;
              r_run_ack <= 1'b1;
            end
          end
          S_ADDR_HI: begin
            r_addr_hi <= rx_data;
            r_csum    <= r_csum + rx_data;
          end
          S_ADDR_LO: begin
            r_base <= ADDR_W'({r_addr_hi, rx_data});
            r_csum <= r_csum + rx_data;
          end
          S_LEN_HI: begin
            r_len_hi <= rx_data;
            r_csum   <= r_csum + rx_data;
          end
          S_LEN_LO: begin
            r_len  <= {r_len_hi, rx_data};
            r_csum <= r_csum + rx_data;
          end
          S_DATA: begin
            r_csum     <= r_csum + rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // Address wraps modulo 2^ADDR_W by construction.
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_base + ADDR_W'(r_word_idx);
              r_mem_wdata <= {rx_data, r_word};
              r_word_idx  <= r_word_idx + 16'd1;
            end else begin
              r_word <= {rx_data, r_word[23:8]};
            end
          end
          S_CSUM: r_resp <= (rx_data == r_csum) ? RSP_ACK : RSP_NAK;
          default: ;
        endcase
      end
      if (w_timeout) r_resp <= RSP_NAK;
    end
  end

  boot_resp_tx u_resp_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_resp_start),
    .i_byte    (r_resp),
    .i_tx_done (tx_done),
    .o_trmt    (trmt),
    .o_tx_data (tx_data),
    .o_done    (w_resp_done)
  );

  assign clr_rx_rdy = w_accept;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_rst_n  = (r_state == S_RUN);
  assign busy       = (r_state != S_IDLE) && (r_state != S_RUN);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_bootloader.sv
module tb_uart_bootloader;
  import boot_pkg::*;

  localparam int ADDR_W = 14;
  localparam int TO_CYC = 1000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  state_t      dbg_state;

  always #5 clk = ~clk;

  uart_bootloader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .tx_done    (tx_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [ADDR_W+31:0] exp_wr_q[$];
  logic [7:0]         exp_tx_q[$];
  int          tx_count = 0;
  int          hold_err = 0;
  logic [7:0]  hold_byte = 8'h00;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: every write and every response byte must be predicted.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_wr_q.size() == 0) check("wr_expected", 64'(exp_wr_q.size()), 64'd1);
      else check("mem_write", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
    end
    if (trmt) begin
      tx_count++;
      hold_byte = tx_data;
      if (exp_tx_q.size() == 0) check("tx_expected", 64'(exp_tx_q.size()), 64'd1);
      else check("tx_byte", tx_data, exp_tx_q.pop_front());
    end else if (dbg_state == S_RESP_WAIT && tx_data !== hold_byte) begin
      hold_err++;
    end
  end

  // UART transmitter model: tx_done drops on trmt, rises after a random time.
  initial begin
    tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (trmt && rst_n) begin
        tx_done = 1'b0;
        repeat ($urandom_range(2, 12)) @(negedge clk);
        tx_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    while (!clr_rx_rdy && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) check("rx_accept", clr_rx_rdy, 1'b1);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
  endtask

  task automatic send_sum(input logic [7:0] b, inout logic [7:0] s);
    s = s + b;
    send_byte(b);
  endtask

  task automatic send_frame(input logic [15:0] base, input int n,
                            input logic [31:0] w[4], input logic bad);
    logic [7:0]  s;
    logic [15:0] len;
    s   = 8'h00;
    len = 16'(n);
    send_byte(CMD_WRITE);
    send_sum(base[15:8], s);
    send_sum(base[7:0], s);
    send_sum(len[15:8], s);
    send_sum(len[7:0], s);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) send_sum(w[i][8*k +: 8], s);
    send_byte(bad ? s + 8'd1 : s);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (dbg_state != S_IDLE && t < 300);
    check("frame_idle", dbg_state, S_IDLE);
    check("wr_drain", 64'(exp_wr_q.size()), 64'd0);
    check("tx_drain", 64'(exp_tx_q.size()), 64'd0);
  endtask

  task automatic rst_assert();
    @(negedge clk);
    rst_n   = 1'b0;
    rx_data = 8'h33;
    rx_rdy  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic rst_release();
    rx_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals();
    check("rst_state",   dbg_state,  S_IDLE);
    check("rst_clr",     clr_rx_rdy, 1'b0);
    check("rst_trmt",    trmt,       1'b0);
    check("rst_tx_data", tx_data,    8'h00);
    check("rst_we",      mem_we,     1'b0);
    check("rst_addr",    mem_addr,   '0);
    check("rst_wdata",   mem_wdata,  32'h0);
    check("rst_cpu",     cpu_rst_n,  1'b0);
    check("rst_busy",    busy,       1'b0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0]       base;
    int                n;
    logic [31:0]       d0;
    logic [31:0]       d1;
    logic              bad;
    logic [7:0]        rsp;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
  } vec_t;

  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles limit 50000", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] w[4];
    logic [15:0] base;
    int          n, c0, t;
    logic        bad;

    vt[0] = '{16'h0010, 1, 32'hDEADBEEF, 32'h0,        1'b0, RSP_ACK, 14'h0010, 14'h0000};
    vt[1] = '{16'h0010, 1, 32'hDEADBEEF, 32'h0,        1'b1, RSP_NAK, 14'h0010, 14'h0000};
    vt[2] = '{16'h3FFF, 2, 32'h11223344, 32'h55667788, 1'b0, RSP_ACK, 14'h3FFF, 14'h0000};
    vt[3] = '{16'h0000, 0, 32'h0,        32'h0,        1'b0, RSP_ACK, 14'h0000, 14'h0000};
    vt[4] = '{16'hFFFE, 2, 32'h0BADF00D, 32'hCAFEBABE, 1'b0, RSP_ACK, 14'h3FFE, 14'h3FFF};
    vt[5] = '{16'h1234, 0, 32'h0,        32'h0,        1'b1, RSP_NAK, 14'h0000, 14'h0000};

    // Reset values, with a byte pending that must not be acknowledged.
    rst_assert();
    check_reset_vals();
    rst_release();

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      w = '{vt[v].d0, vt[v].d1, 32'h0, 32'h0};
      if (vt[v].n >= 1) exp_wr_q.push_back({vt[v].a0, vt[v].d0});
      if (vt[v].n >= 2) exp_wr_q.push_back({vt[v].a1, vt[v].d1});
      exp_tx_q.push_back(vt[v].rsp);
      send_frame(vt[v].base, vt[v].n, w, vt[v].bad);
      wait_idle();
    end

    // Reset in the middle of the data phase: no write, no response.
    send_byte(CMD_WRITE);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h02);
    check("mid_busy", busy, 1'b1);
    check("mid_state", dbg_state, S_DATA);
    send_byte(8'hAA);
    send_byte(8'hBB);
    c0 = tx_count;
    rst_assert();
    check_reset_vals();
    rst_release();
    repeat (20) @(negedge clk);
    check("no_trmt_after_rst", 64'(tx_count), 64'(c0));
    w = '{32'h01020304, 32'h0, 32'h0, 32'h0};
    exp_wr_q.push_back({14'h0020, 32'h01020304});
    exp_tx_q.push_back(RSP_ACK);
    send_frame(16'h0020, 1, w, 1'b0);
    wait_idle();

    // Randomized frames against the reference model.
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] g;
        g = 8'($urandom_range(0, 255));
        if (g == CMD_WRITE || g == CMD_RUN) g = 8'h00;
        send_byte(g);
      end
      base = 16'($urandom);
      n    = $urandom_range(0, 4);
      bad  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      for (int i = 0; i < n; i++)
        exp_wr_q.push_back({ADDR_W'(int'(base) + i), w[i]});
      exp_tx_q.push_back(bad ? RSP_NAK : RSP_ACK);
      send_frame(base, n, w, bad);
      wait_idle();
    end

`ifdef BOOT_TIMEOUT_EN
    // Stalled frame is answered with NAK, then the next frame works.
    exp_tx_q.push_back(RSP_NAK);
    send_byte(CMD_WRITE);
    send_byte(8'h00);
    c0 = int'(cyc);
    t  = tx_count;
    for (int i = 0; i < 3000 && tx_count == t; i++) @(negedge clk);
    check("timeout_trmt", 64'(tx_count), 64'(t + 1));
    check("timeout_lat_ok", (int'(cyc) - c0 >= 995) && (int'(cyc) - c0 <= 1005), 1'b1);
    wait_idle();
    w = '{32'hA5A55A5A, 32'h0, 32'h0, 32'h0};
    exp_wr_q.push_back({14'h0100, 32'hA5A55A5A});
    exp_tx_q.push_back(RSP_ACK);
    send_frame(16'h0100, 1, w, 1'b0);
    wait_idle();
`endif

    // Garbage byte, then CMD_RUN: CPU released only after tx_done.
    send_byte(8'h33);
    check("garbage_idle", dbg_state, S_IDLE);
    exp_tx_q.push_back(RSP_ACK);
    t = tx_count;
    send_byte(CMD_RUN);
    for (int i = 0; i < 50 && tx_count == t; i++) begin
      @(negedge clk);
      #2;
    end
    check("run_trmt", 64'(tx_count), 64'(t + 1));
    for (int i = 0; i < 50 && !tx_done; i++) begin
      check("cpu_held", cpu_rst_n, 1'b0);
      @(negedge clk);
      #2;
    end
    check("cpu_held_done", cpu_rst_n, 1'b0);
    @(posedge clk);
    #2;
    check("cpu_released", cpu_rst_n, 1'b1);
    check("run_busy", busy, 1'b0);
    check("run_state", dbg_state, S_RUN);
    send_byte(CMD_WRITE);
    send_byte(8'h00);
    send_byte(CMD_RUN);
    send_byte(8'h01);
    repeat (10) @(negedge clk);
    check("run_terminal", dbg_state, S_RUN);
    check("run_cpu", cpu_rst_n, 1'b1);
    check("run_wr_drain", 64'(exp_wr_q.size()), 64'd0);
    check("run_tx_drain", 64'(exp_tx_q.size()), 64'd0);
    check("tx_hold", 64'(hold_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
